// File: rtl/gpio_io_ctrl_pkg.sv
// Shared register offsets, default widths and debouncer state encoding
// for the switch/LED peripheral.
package gpio_io_ctrl_pkg;

    localparam logic [1:0] GpioSwAddr   = 2'd0;
    localparam logic [1:0] GpioLedAddr  = 2'd1;
    localparam logic [1:0] GpioStatAddr = 2'd2;
    localparam logic [1:0] GpioCntAddr  = 2'd3;

    localparam int SwitchWide = 16;
    localparam int LedWide    = 16;

    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_e;

endpackage

// File: rtl/gpio_io_ctrl_switch_debounce.sv
// Two-flop synchroniser followed by a restart-on-bounce debouncer; emits the
// accepted switch value and a one-cycle pulse when that value actually changes.
module switch_debounce
    import gpio_io_ctrl_pkg::*;
#(
    parameter int          SW_WIDTH        = SwitchWide,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] switch_on,
    output logic [SW_WIDTH-1:0] sw_stable,
    output logic                chg_pulse
);

    logic [SW_WIDTH-1:0] sync1_reg;
    logic [SW_WIDTH-1:0] sync2_reg;
    logic [SW_WIDTH-1:0] sw_sync;

    genvar gi;
    generate
        for (gi = 0; gi < SW_WIDTH; gi = gi + 1) begin : g_sync
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi] <= switch_on[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    assign sw_sync = sync2_reg;

    db_state_e           state_reg,  state_next;
    logic [19:0]         cnt_reg,    cnt_next;
    logic [SW_WIDTH-1:0] cand_reg,   cand_next;
    logic [SW_WIDTH-1:0] stable_reg, stable_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= DB_IDLE;
            cnt_reg    <= 20'd0;
            cand_reg   <= '0;
            stable_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            cand_reg   <= cand_next;
            stable_reg <= stable_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        cand_next   = cand_reg;
        stable_next = stable_reg;
        chg_pulse   = 1'b0;
        case (state_reg)
            DB_IDLE: begin
                cnt_next = 20'd0;
                if (sw_sync != stable_reg) begin
                    state_next = DB_COUNT;
                    cnt_next   = 20'd1;
                    cand_next  = sw_sync;
                end
            end
            DB_COUNT: begin
                // Any disagreement with the candidate restarts the wait from scratch.
                if (sw_sync != cand_reg) begin
                    cand_next = sw_sync;
                    cnt_next  = 20'd1;
                end else if (cnt_reg == DEBOUNCE_CYCLES - 20'd1) begin
                    stable_next = cand_reg;
                    state_next  = DB_IDLE;
                    cnt_next    = 20'd0;
                    chg_pulse   = (cand_reg != stable_reg);
                end else begin
                    cnt_next = cnt_reg + 20'd1;
                end
            end
            default: begin
                state_next = DB_IDLE;
                cnt_next   = 20'd0;
            end
        endcase
    end

    assign sw_stable = stable_reg;

endmodule

// File: rtl/gpio_io_ctrl.sv
// Memory-mapped switch/LED peripheral: debounced switch read-back, LED register,
// sticky write-1-to-clear change flag and a free-running cycle counter.
module gpio_io_ctrl
    import gpio_io_ctrl_pkg::*;
#(
    parameter int          SW_WIDTH        = SwitchWide,
    parameter int          LED_WIDTH       = LedWide,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 we,
    input  logic [31:0]          addr,
    input  logic [31:0]          data_i,
    output logic [31:0]          data_o,
    input  logic [SW_WIDTH-1:0]  switch_on,
    output logic [LED_WIDTH-1:0] led_out
);

    logic [SW_WIDTH-1:0]  sw_stable;
    logic                 chg_pulse;
    logic [LED_WIDTH-1:0] led_reg;
    logic                 chg_reg;
    logic [31:0]          cnt_reg;
    logic                 wr_en;
    logic [1:0]           reg_sel;
    logic                 unused_bits;

    switch_debounce #(
        .SW_WIDTH        (SW_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .switch_on (switch_on),
        .sw_stable (sw_stable),
        .chg_pulse (chg_pulse)
    );

    assign wr_en   = ce & we;
    assign reg_sel = addr[3:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_reg <= '0;
            chg_reg <= 1'b0;
            cnt_reg <= 32'd0;
        end else begin
            cnt_reg <= cnt_reg + 32'd1;
            if (wr_en && reg_sel == GpioLedAddr) begin
                led_reg <= data_i[LED_WIDTH-1:0];
            end
            // A change landing on the same edge as a clear must not be lost.
            if (chg_pulse) begin
                chg_reg <= 1'b1;
            end else if (wr_en && reg_sel == GpioStatAddr && data_i[0]) begin
                chg_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        data_o = 32'd0;
        if (ce && !we) begin
            case (reg_sel)
                GpioSwAddr:   data_o[SW_WIDTH-1:0]  = sw_stable;
                GpioLedAddr:  data_o[LED_WIDTH-1:0] = led_reg;
                GpioStatAddr: data_o[0]             = chg_reg;
                default:      data_o                = cnt_reg;
            endcase
        end
    end

    assign led_out = led_reg;

    assign unused_bits = ^{addr[31:4], addr[1:0], data_i};

endmodule

// File: tb/tb_gpio_io_ctrl.sv
// Bench for gpio_io_ctrl with an 8-cycle debounce: directed table, timing
// sequences and a randomized run against a run-length reference model.
module tb_gpio_io_ctrl;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] data_i = 32'd0;
    logic [31:0] data_o;
    logic [15:0] switch_on = 16'd0;
    logic [15:0] led_out;

    int vectors = 0;
    int miscompares = 0;

    gpio_io_ctrl #(
        .SW_WIDTH        (16),
        .LED_WIDTH       (16),
        .DEBOUNCE_CYCLES (20'd8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .we        (we),
        .addr      (addr),
        .data_i    (data_i),
        .data_o    (data_o),
        .switch_on (switch_on),
        .led_out   (led_out)
    );

    always #5 clk = ~clk;

    // Reference model: a new value is accepted once it has been seen on the
    // synchronised input for D consecutive samples since the last disagreement.
    logic [15:0] m_s1, m_s2, m_stable, m_last, m_led;
    logic        m_armed, m_chg, m_pulse;
    int          m_run;
    logic [31:0] m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0; m_last = 0; m_led = 0;
            m_armed = 0; m_chg = 0; m_run = 0; m_cnt = 0;
        end else begin
            m_pulse = 1'b0;
            if (!m_armed) begin
                if (m_s2 != m_stable) begin
                    m_armed = 1'b1;
                    m_run   = 1;
                    m_last  = m_s2;
                end
            end else begin
                if (m_s2 == m_last) m_run = m_run + 1;
                else begin
                    m_last = m_s2;
                    m_run  = 1;
                end
                if (m_run == D) begin
                    m_pulse  = (m_last != m_stable);
                    m_stable = m_last;
                    m_armed  = 1'b0;
                end
            end
            if (m_pulse) m_chg = 1'b1;
            else if (ce && we && addr[3:2] == 2'd2 && data_i[0]) m_chg = 1'b0;
            if (ce && we && addr[3:2] == 2'd1) m_led = data_i[15:0];
            m_cnt = m_cnt + 1;
            m_s2 = m_s1;
            m_s1 = switch_on;
        end
    end

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        case (a[3:2])
            2'd0:    return {16'd0, m_stable};
            2'd1:    return {16'd0, m_led};
            2'd2:    return {31'd0, m_chg};
            default: return m_cnt;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        ce = 1'b1; we = 1'b0; addr = a;
        #1;
        check(name, data_o, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ce = 1'b1; we = 1'b1; addr = a; data_i = d;
        @(negedge clk);
        ce = 1'b0; we = 1'b0; data_i = 32'd0;
    endtask

    // Each step: one edge, then SW and STAT checked; new value/CHG expected from edge thr.
    task automatic watch(input string tag, input int n, input int thr,
                         input logic [15:0] old_v, input logic [15:0] new_v, input logic chg);
        for (int e = 1; e <= n; e++) begin
            @(negedge clk);
            chk_rd($sformatf("%s_sw_e%0d", tag, e), 32'h0, {16'd0, (e >= thr) ? new_v : old_v});
            chk_rd($sformatf("%s_chg_e%0d", tag, e), 32'h8, {31'd0, chg && (e >= thr)});
        end
    endtask

    typedef struct {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [15:0] exp_led;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // One operation per cycle, starting on the first cycle after reset release.
        tbl[0]  = '{1'b1, 1'b0, 32'h0,        32'h0,        32'h0,     16'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h4,        32'h0,        32'h0,     16'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h8,        32'h0,        32'h0,     16'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'hC,        32'h0,        32'h3,     16'h0};
        tbl[4]  = '{1'b0, 1'b0, 32'hC,        32'h0,        32'h0,     16'h0};
        tbl[5]  = '{1'b1, 1'b1, 32'h4,        32'h0000A5A5, 32'h0,     16'h0};
        tbl[6]  = '{1'b1, 1'b0, 32'h4,        32'h0,        32'hA5A5,  16'hA5A5};
        tbl[7]  = '{1'b1, 1'b1, 32'h4,        32'hFFFF1234, 32'h0,     16'hA5A5};
        tbl[8]  = '{1'b1, 1'b0, 32'h4,        32'h0,        32'h1234,  16'h1234};
        tbl[9]  = '{1'b1, 1'b1, 32'h8,        32'h0,        32'h0,     16'h1234};
        tbl[10] = '{1'b1, 1'b0, 32'h8,        32'h0,        32'h0,     16'h1234};
        tbl[11] = '{1'b1, 1'b1, 32'hC,        32'h0,        32'h0,     16'h1234};
        tbl[12] = '{1'b1, 1'b0, 32'hC,        32'h0,        32'hC,     16'h1234};
        tbl[13] = '{1'b1, 1'b0, 32'hFFFFFFF4, 32'h0,        32'h1234,  16'h1234};

        repeat (3) @(negedge clk);
        check("rst_data_o", data_o, 32'h0);
        check("rst_led", {16'd0, led_out}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            ce = tbl[i].ce; we = tbl[i].we; addr = tbl[i].addr; data_i = tbl[i].wdata;
            #1;
            check($sformatf("tbl%0d_rd", i), data_o, tbl[i].exp_rd);
            check($sformatf("tbl%0d_led", i), {16'd0, led_out}, {16'd0, tbl[i].exp_led});
            @(negedge clk);
        end
        ce = 1'b0; we = 1'b0; data_i = 32'd0;

        // Clean change: accepted exactly 10 edges after the pin moves.
        switch_on = 16'h0003;
        watch("clean", 12, 10, 16'h0, 16'h3, 1'b1);
        wr(32'h8, 32'h1);
        chk_rd("w1c_clear", 32'h8, 32'h0);

        switch_on = 16'h0000;
        watch("ret0", 12, 10, 16'h3, 16'h0, 1'b1);
        wr(32'h8, 32'h1);

        // Bounce, then hold: only the final transition counts.
        switch_on = 16'h1; watch("bnc_a", 3, 99, 16'h0, 16'h0, 1'b0);
        switch_on = 16'h0; watch("bnc_b", 3, 99, 16'h0, 16'h0, 1'b0);
        switch_on = 16'h1; watch("bnc", 12, 10, 16'h0, 16'h1, 1'b1);
        wr(32'h8, 32'h1);
        watch("bnc_once", 12, 99, 16'h1, 16'h1, 1'b0);

        switch_on = 16'h0;
        watch("ret0b", 12, 10, 16'h1, 16'h0, 1'b1);
        wr(32'h8, 32'h1);

        // Short pulse must be rejected without raising CHG.
        switch_on = 16'h1; watch("pls_a", 5, 99, 16'h0, 16'h0, 1'b0);
        switch_on = 16'h0; watch("pls_b", 20, 99, 16'h0, 16'h0, 1'b0);

        // CHG set and W1C on the same edge: set wins.
        switch_on = 16'h5;
        watch("col", 9, 99, 16'h0, 16'h0, 1'b0);
        wr(32'h8, 32'h1);
        chk_rd("col_chg", 32'h8, 32'h1);
        chk_rd("col_sw", 32'h0, 32'h5);
        @(negedge clk);
        wr(32'h8, 32'h1);
        chk_rd("col_cleared", 32'h8, 32'h0);

        // Reset in the middle of a pending change.
        switch_on = 16'h0;
        watch("pre_rst", 5, 99, 16'h5, 16'h5, 1'b0);
        #2 rst = 1'b1;
        chk_rd("inrst_sw", 32'h0, 32'h0);
        chk_rd("inrst_led", 32'h4, 32'h0);
        chk_rd("inrst_cnt", 32'hC, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        watch("post_rst", 15, 99, 16'h0, 16'h0, 1'b0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] exp;
            @(negedge clk);
            if ($urandom_range(15) == 0) switch_on = 16'($urandom_range(15));
            a = $urandom;
            ce = ($urandom_range(3) != 0);
            we = ($urandom_range(7) == 0);
            addr = a;
            data_i = $urandom;
            #1;
            exp = (ce && !we) ? mdl_read(addr) : 32'h0;
            check($sformatf("rnd%0d_rd", i), data_o, exp);
            check($sformatf("rnd%0d_led", i), {16'd0, led_out}, {16'd0, m_led});
        end
        ce = 1'b0; we = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
